// File: rtl/daq_evbuf_pkg.sv
// Shared types and default sizing for the DAQ event buffer.
package daq_evbuf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DROP_W_DEF = 16;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ACCEPT  = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    // Number of RAM entries for a given address width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/daq_evbuf_ram.sv
// Simple dual-port inferred block RAM: one write port, one registered read port, no reset.
module daq_evbuf_ram
    import daq_evbuf_pkg::*;
#(
    parameter int unsigned WIDTH  = DATA_W_DEF + 1,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/daq_event_buffer.sv
// Framed DAQ event buffer: whole events are committed to a circular RAM and replayed to a valid/ready reader.
// Define DAQ_EVBUF_STATS_EN to build the words_used / evt_total statistics counters.
module daq_event_buffer
    import daq_evbuf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W:0]   evt_count,
    output logic [DROP_W-1:0] drop_count,
    output logic [ADDR_W:0]   words_used,
    output logic [31:0]       evt_total
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned RAM_W = DATA_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(depth_of(ADDR_W));

    wr_state_e         wr_state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  commit_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  fetch_ptr;

    logic              full_c;
    logic              accept_c;
    logic              overflow_c;
    logic              commit_c;

    logic              rd_pend;
    logic              out_vld;
    logic [RAM_W-1:0]  out_word;
    logic              pf_vld;
    logic [RAM_W-1:0]  pf_word;
    logic [RAM_W-1:0]  ram_q;
    logic              pop_c;
    logic              pop_last_c;
    logic              issue_c;
    logic [1:0]        occ_c;

    // rd_ptr marks the oldest word not yet handed to the consumer, so
    // prefetched words still hold their slots until they are popped.
    assign full_c     = (wr_ptr - rd_ptr) == DEPTH;
    assign accept_c   = wr_valid && !full_c && (wr_state != WR_DISCARD);
    assign overflow_c = wr_valid &&  full_c && (wr_state != WR_DISCARD);
    assign commit_c   = accept_c && wr_last;

    // Write-side framing FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state   <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            case (wr_state)
                WR_IDLE, WR_ACCEPT: begin
                    if (wr_valid) begin
                        if (full_c) begin
                            wr_ptr   <= commit_ptr;
                            wr_state <= wr_last ? WR_IDLE : WR_DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (wr_last) begin
                                commit_ptr <= wr_ptr + PTR_W'(1);
                                wr_state   <= WR_IDLE;
                            end else begin
                                wr_state   <= WR_ACCEPT;
                            end
                        end
                    end
                end
                WR_DISCARD: begin
                    if (wr_valid && wr_last) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    daq_evbuf_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept_c),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata ({wr_last, wr_data}),
        .re    (issue_c),
        .raddr (fetch_ptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    // Read pipeline: RAM read -> optional prefetch slot -> output register.
    // A read is issued only if its data is guaranteed a free slot on arrival.
    assign pop_c      = out_vld && rd_ready;
    assign pop_last_c = pop_c && out_word[DATA_W];
    assign occ_c      = {1'b0, out_vld} + {1'b0, pf_vld} + {1'b0, rd_pend} - {1'b0, pop_c};
    assign issue_c    = (fetch_ptr != commit_ptr) && (occ_c < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            out_vld   <= 1'b0;
            out_word  <= '0;
            pf_vld    <= 1'b0;
            pf_word   <= '0;
        end else begin
            rd_pend <= issue_c;
            if (issue_c) begin
                fetch_ptr <= fetch_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (pf_vld) begin
                // A full prefetch slot implies no read is in flight.
                if (pop_c) begin
                    out_word <= pf_word;
                    pf_vld   <= 1'b0;
                end
            end else if (!out_vld || pop_c) begin
                out_vld <= rd_pend;
                if (rd_pend) begin
                    out_word <= ram_q;
                end
            end else if (rd_pend) begin
                pf_vld  <= 1'b1;
                pf_word <= ram_q;
            end
        end
    end

    assign rd_valid = out_vld;
    assign rd_data  = out_word[DATA_W-1:0];
    assign rd_last  = out_word[DATA_W];

    // Committed-but-unread events and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count  <= '0;
            drop_count <= '0;
        end else begin
            case ({commit_c, pop_last_c})
                2'b10:   evt_count <= evt_count + PTR_W'(1);
                2'b01:   evt_count <= evt_count - PTR_W'(1);
                default: evt_count <= evt_count;
            endcase
            if (overflow_c && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

`ifdef DAQ_EVBUF_STATS_EN
    logic [PTR_W-1:0] words_used_q;
    logic [31:0]      evt_total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_used_q <= '0;
            evt_total_q  <= '0;
        end else begin
            words_used_q <= wr_ptr - rd_ptr;
            if (commit_c) begin
                evt_total_q <= evt_total_q + 32'd1;
            end
        end
    end

    assign words_used = words_used_q;
    assign evt_total  = evt_total_q;
`else
    assign words_used = '0;
    assign evt_total  = '0;
`endif

endmodule
